// File: rtl/seq_pattern_detector_pkg.sv
// seq_pattern_detector: shared constants and elaboration-time helpers.
// Used by the detector core and its next-state sub-module.
package seq_det_pkg;

  localparam int PAT_MAX_W = 1024;

  typedef logic [PAT_MAX_W-1:0] pat_t;

  function automatic int state_w(input int pat_len);
    return $clog2(pat_len);
  endfunction

  function automatic bit sym_eq(
    input pat_t p,
    input int   sym_w,
    input int   pat_len,
    input int   a,
    input int   b
  );
    bit eq;
    eq = 1'b1;
    for (int i = 0; i < sym_w; i++) begin
      if (p[(pat_len-1-a)*sym_w+i] != p[(pat_len-1-b)*sym_w+i])
        eq = 1'b0;
    end
    return eq;
  endfunction

  function automatic bit prefix_ok(
    input pat_t p,
    input int   sym_w,
    input int   pat_len,
    input int   s,
    input int   k
  );
    bit ok;
    ok = (k >= 1) && (k <= s);
    for (int i = 0; i <= k - 2; i++) begin
      if (ok && !sym_eq(p, sym_w, pat_len, i, s-k+1+i))
        ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic int fail_len(
    input pat_t p,
    input int   sym_w,
    input int   pat_len
  );
    int best;
    bit ok;
    best = 0;
    for (int b = 1; b < pat_len; b++) begin
      ok = 1'b1;
      for (int i = 0; i < b; i++) begin
        if (!sym_eq(p, sym_w, pat_len, i, pat_len-b+i))
          ok = 1'b0;
      end
      if (ok)
        best = b;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// seq_pattern_detector: symbol-in / match-out bundle.
// match_cnt exists only when SEQ_DET_COUNT_EN is defined.
interface seq_pattern_detector_if #(
  parameter int SYM_W = 2,
  parameter int SW    = 2
`ifdef SEQ_DET_COUNT_EN
  ,
  parameter int CNT_W = 8
`endif
);

  logic             clear;
  logic             sym_valid;
  logic [SYM_W-1:0] sym;
  logic             match;
  logic [SW-1:0]    state_dbg;
`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  modport master (
    output clear,
    output sym_valid,
    output sym,
    input  match,
`ifdef SEQ_DET_COUNT_EN
    input  match_cnt,
`endif
    input  state_dbg
  );

  modport slave (
    input  clear,
    input  sym_valid,
    input  sym,
    output match,
`ifdef SEQ_DET_COUNT_EN
    output match_cnt,
`endif
    output state_dbg
  );

endinterface

// File: rtl/seq_pattern_detector_next.sv
// seq_det_next: combinational prefix-length update for one symbol.
// Mismatch fallback is a priority chain over k; larger k wins.
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int PAT_LEN = 4,
  parameter logic [SYM_W*PAT_LEN-1:0] PATTERN =
    {2'b01, 2'b10, 2'b11, 2'b00},
  parameter int OVERLAP = 1,
  localparam int SW = state_w(PAT_LEN)
) (
  input  logic [SW-1:0]    s,
  input  logic [SYM_W-1:0] sym,
  output logic [SW-1:0]    next_s,
  output logic             hit
);

  localparam pat_t PAT_X = pat_t'(PATTERN);
  localparam int FAIL = fail_len(PAT_X, SYM_W, PAT_LEN);
  localparam int NOK = PAT_LEN * PAT_LEN;

  function automatic logic [NOK-1:0] build_ok();
    logic [NOK-1:0] t;
    t = '0;
    for (int r = 0; r < PAT_LEN; r++)
      for (int k = 0; k < PAT_LEN; k++)
        t[r*PAT_LEN+k] = prefix_ok(PAT_X, SYM_W, PAT_LEN, r, k);
    return t;
  endfunction

  localparam logic [NOK-1:0] OK_TAB = build_ok();

  localparam logic [SW-1:0] MATCH_S =
    (OVERLAP != 0) ? SW'(FAIL) : '0;

  logic [SYM_W-1:0]   p_s;
  logic [PAT_LEN-1:0] ok_row;

  // Extend, complete, or fall back the matched prefix.
  always_comb begin
    next_s = '0;
    hit    = 1'b0;
    p_s    = '0;
    ok_row = '0;
    for (int r = 0; r < PAT_LEN; r++) begin
      if (int'(s) == r) begin
        p_s    = PATTERN[(PAT_LEN-1-r)*SYM_W +: SYM_W];
        ok_row = OK_TAB[r*PAT_LEN +: PAT_LEN];
      end
    end
    if (sym == p_s) begin
      if (int'(s) == PAT_LEN - 1) begin
        hit    = 1'b1;
        next_s = MATCH_S;
      end else begin
        next_s = s + 1'b1;
      end
    end else begin
      for (int k = 1; k < PAT_LEN; k++) begin
        if (ok_row[k] &&
            sym == PATTERN[(PAT_LEN-k)*SYM_W +: SYM_W])
          next_s = SW'(k);
      end
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: Moore pattern detector over a symbol stream.
// Optional saturating match counter via SEQ_DET_COUNT_EN.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int PAT_LEN = 4,
  parameter logic [SYM_W*PAT_LEN-1:0] PATTERN =
    {2'b01, 2'b10, 2'b11, 2'b00},
  parameter int OVERLAP = 1
`ifdef SEQ_DET_COUNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input logic clk,
  input logic rst,
  seq_pattern_detector_if.slave bus
);

  localparam int SW = state_w(PAT_LEN);

  logic [SW-1:0] s_q;
  logic [SW-1:0] next_s;
  logic          match_q;
  logic          hit;

  seq_det_next #(
    .SYM_W   (SYM_W),
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP)
  ) u_next (
    .s      (s_q),
    .sym    (bus.sym),
    .next_s (next_s),
    .hit    (hit)
  );

  // Prefix state and one-cycle match pulse; clear beats valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      match_q <= 1'b0;
    end else if (bus.clear) begin
      s_q     <= '0;
      match_q <= 1'b0;
    end else if (bus.sym_valid) begin
      s_q     <= next_s;
      match_q <= hit;
    end else begin
      match_q <= 1'b0;
    end
  end

  assign bus.state_dbg = s_q;
  assign bus.match     = match_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating match count, bumped on the edge that raises match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.clear) begin
      cnt_q <= '0;
    end else if (bus.sym_valid && hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.match_cnt = cnt_q;
`endif

endmodule
